instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
Encoder counterpart of the main control decoder. It accepts symbolic instruction descriptors (operation select plus fields) over a valid/ready handshake and packs them into 32-bit MIPS words using the opcode/funct map the decoder recognises. It writes the words sequentially into instruction memory through a registered write port, and serves as the bench and boot-time program loader for the monocycle core.

Parameters:
ADDR_W, 8, word-address width of instruction memory; capacity DEPTH = 2**ADDR_W words
ERR_ON_FUNCT_JR, 1, when 1 an R_ALU descriptor with funct=6'b001000 is rejected (JR must use OP_JR)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous: zero the write address, done and err
in_valid  input  1  descriptor valid
in_ready  output  1  descriptor accepted when in_valid & in_ready
op_sel  input  4  operation select (enum below)
rs  input  5  source register field
rt  input  5  target register field
rd  input  5  destination register field (R_ALU only)
shamt  input  5  shift amount (R_ALU only)
funct  input  6  function field (R_ALU only)
imm16  input  16  immediate (I-type)
target26  input  26  jump target (J/JAL)
wr_en  output  1  instruction-memory write strobe
wr_addr  output  ADDR_W  word address of the write
wr_data  output  32  encoded instruction
count  output  ADDR_W+1  words written since reset/clear
done  output  1  memory full (count == DEPTH)
err  output  1  sticky: an invalid descriptor was received
err_pulse  output  1  one-cycle strobe per rejected descriptor

Behaviour:
- Reset (rst_n low, async): in_ready=0 while asserted; wr_en=0, wr_addr=0, wr_data=0, count=0, done=0, err=0, err_pulse=0. Reset mid-write drops wr_en immediately, and the word is lost.
- op_sel encoding: 0 R_ALU, 1 JR, 2 LW, 3 SW, 4 BEQ, 5 BNE, 6 ADDI, 7 ANDI, 8 ORI, 9 XORI, 10 SLTI, 11 SLTIU, 12 LUI, 13 J, 14 JAL, 15 invalid.
- Packing:
  - R_ALU = {000000, rs, rt, rd, shamt, funct}.
  - JR = {000000, rs, 15'b0, 001000}.
  - I-type = {opcode, rs, rt, imm16}, with opcodes LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, SLTI 001010, SLTIU 001011.
  - LUI = {001111, 00000, rt, imm16}, with rs forced to 0.
  - J = {000010, target26}; JAL = {000011, target26}.
  - Unused input fields are ignored.
- in_ready = rst_n & ~done & ~clear.
- Latency: descriptor accepted at edge N, so wr_en=1 with wr_addr and wr_data stable during cycle N+1. Throughput is 1 word/cycle; wr_en is a single-cycle pulse per word.
- On a valid accept:
  - wr_addr takes the current count[ADDR_W-1:0].
  - count increments.
  - done becomes 1 when count reaches DEPTH.
  - Once done=1, in_ready=0; there is no wrap-around and the last address is never overwritten.
- Invalid descriptor (op_sel=15, or R_ALU with funct=001000 when ERR_ON_FUNCT_JR=1): the handshake still completes, but there is no wr_en and count is unchanged. err_pulse=1 in cycle N+1 and err is set (sticky).
- clear: synchronous. Next cycle count=0, done=0, err=0, wr_en=0. clear has priority over a concurrent in_valid, since in_ready=0 that cycle and nothing is accepted.
- FSM (2 bits): LOAD (accepting), FULL (done=1, waits for clear). LOAD->FULL on the accept that makes count==DEPTH; FULL->LOAD on clear. Output register stage is separate from the FSM, so wr_en can pulse in the first FULL cycle.
- in_valid with in_ready=0: descriptor is not consumed, and the source must hold it.

Decomposition:
- Shared package mips_isa_pkg: opcode localparams (R_TYPE, LW, SW, BEQ, BNE, ADDI, ANDI, ORI, XORI, SLTI, SLTIU, LUI, J, JAL), FUNCT_JR=6'b001000, and the op_sel enum. The control decoder imports the same constants.
- One combinational sub-module, instr_field_pack: op_sel and fields in, {word, invalid} out. The top holds the handshake, counter, FSM and output registers.

Test Plan:
- ADDI op_sel=6, rs=0, rt=8, imm16=0x0005 -> next cycle wr_en=1, wr_addr=0, wr_data=0x20080005, count=1.
- R_ALU rs=8, rt=9, rd=10, shamt=0, funct=0x20, then JR rs=31 on back-to-back cycles -> wr_data=0x01095020 @0, then 0x03E00008 @1.
- LW rt=9, rs=8, imm16=0xFFFC -> 0x8D09FFFC; JAL target26=0x0100000 -> 0x0C100000; LUI rs=7, rt=1, imm16=0x1234 -> 0x3C011234 (rs zeroed).
- op_sel=15, then R_ALU with funct=0x08 -> no wr_en, err_pulse twice, err=1, count unchanged; after clear -> err=0.
- ADDR_W=2: stream 5 descriptors -> 4 writes at addresses 0..3, done=1, in_ready=0, 5th held; clear with in_valid=1 -> not accepted, and the next write lands at address 0.
- Assert rst_n=0 in the cycle wr_en=1 -> wr_en drops asynchronously, count=0, and no further write after release until a new accept.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// Shared MIPS opcode/funct constants and the loader's operation-select enum.
package mips_isa_pkg;

   localparam logic [5:0] R_TYPE = 6'b000000;
   localparam logic [5:0] LW     = 6'b100011;
   localparam logic [5:0] SW     = 6'b101011;
   localparam logic [5:0] BEQ    = 6'b000100;
   localparam logic [5:0] BNE    = 6'b000101;
   localparam logic [5:0] ADDI   = 6'b001000;
   localparam logic [5:0] ANDI   = 6'b001100;
   localparam logic [5:0] ORI    = 6'b001101;
   localparam logic [5:0] XORI   = 6'b001110;
   localparam logic [5:0] SLTI   = 6'b001010;
   localparam logic [5:0] SLTIU  = 6'b001011;
   localparam logic [5:0] LUI    = 6'b001111;
   localparam logic [5:0] J      = 6'b000010;
   localparam logic [5:0] JAL    = 6'b000011;

   localparam logic [5:0] FUNCT_JR = 6'b001000;

   typedef enum logic [3:0] {
      OP_R_ALU   = 4'd0,
      OP_JR      = 4'd1,
      OP_LW      = 4'd2,
      OP_SW      = 4'd3,
      OP_BEQ     = 4'd4,
      OP_BNE     = 4'd5,
      OP_ADDI    = 4'd6,
      OP_ANDI    = 4'd7,
      OP_ORI     = 4'd8,
      OP_XORI    = 4'd9,
      OP_SLTI    = 4'd10,
      OP_SLTIU   = 4'd11,
      OP_LUI     = 4'd12,
      OP_J       = 4'd13,
      OP_JAL     = 4'd14,
      OP_INVALID = 4'd15
   } op_sel_e;

   function automatic logic [31:0] pack_i(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {opc, rs, rt, imm};
   endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: symbolic descriptor in, 32-bit MIPS word and invalid flag out.
module instr_field_pack
   import mips_isa_pkg::*;
#(
   parameter int ERR_ON_FUNCT_JR = 1
) (
   input  logic [3:0]  op_sel,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [4:0]  shamt,
   input  logic [5:0]  funct,
   input  logic [15:0] imm16,
   input  logic [25:0] target26,
   output logic [31:0] word,
   output logic        invalid
);

   // Select the instruction format for each operation.
   always_comb begin
      word    = '0;
      invalid = 1'b0;
      case (op_sel)
         OP_R_ALU: begin
            word = {R_TYPE, rs, rt, rd, shamt, funct};
            // JR hidden inside an R_ALU descriptor would bypass the dedicated path
            if ((ERR_ON_FUNCT_JR != 0) && (funct == FUNCT_JR)) invalid = 1'b1;
         end
         OP_JR:    word = {R_TYPE, rs, 15'b0, FUNCT_JR};
         OP_LW:    word = pack_i(LW,    rs, rt, imm16);
         OP_SW:    word = pack_i(SW,    rs, rt, imm16);
         OP_BEQ:   word = pack_i(BEQ,   rs, rt, imm16);
         OP_BNE:   word = pack_i(BNE,   rs, rt, imm16);
         OP_ADDI:  word = pack_i(ADDI,  rs, rt, imm16);
         OP_ANDI:  word = pack_i(ANDI,  rs, rt, imm16);
         OP_ORI:   word = pack_i(ORI,   rs, rt, imm16);
         OP_XORI:  word = pack_i(XORI,  rs, rt, imm16);
         OP_SLTI:  word = pack_i(SLTI,  rs, rt, imm16);
         OP_SLTIU: word = pack_i(SLTIU, rs, rt, imm16);
         OP_LUI:   word = pack_i(LUI, 5'd0, rt, imm16);
         OP_J:     word = {J, target26};
         OP_JAL:   word = {JAL, target26};
         default:  invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts descriptors, packs them and writes instruction memory sequentially.
//
//  state   | meaning
//  --------+--------------------------------------------
//  ST_LOAD | accepting descriptors, memory not yet full
//  ST_FULL | count == DEPTH, done=1, waiting for clear
module instr_encoder_loader
   import mips_isa_pkg::*;
#(
   parameter int ADDR_W          = 8,
   parameter int ERR_ON_FUNCT_JR = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        op_sel,
   input  logic [4:0]        rs,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [4:0]        shamt,
   input  logic [5:0]        funct,
   input  logic [15:0]       imm16,
   input  logic [25:0]       target26,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic [ADDR_W:0]   count,
   output logic              done,
   output logic              err,
   output logic              err_pulse
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH-1);

   typedef enum logic [1:0] {ST_LOAD = 2'd0, ST_FULL = 2'd1} ld_state_e;

   ld_state_e   state;
   logic [31:0] word;
   logic        invalid;
   logic        accept;
   logic        word_ok;

   instr_field_pack #(.ERR_ON_FUNCT_JR(ERR_ON_FUNCT_JR)) u_pack (
      .op_sel   (op_sel),
      .rs       (rs),
      .rt       (rt),
      .rd       (rd),
      .shamt    (shamt),
      .funct    (funct),
      .imm16    (imm16),
      .target26 (target26),
      .word     (word),
      .invalid  (invalid)
   );

   assign in_ready = rst_n & ~done & ~clear;
   assign accept   = in_valid & in_ready;
   assign word_ok  = accept & ~invalid;

   // Load/full sequencing; done is the registered FSM output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_LOAD;
         done  <= 1'b0;
      end else if (clear) begin
         state <= ST_LOAD;
         done  <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: if (word_ok && (count == LAST)) begin
               state <= ST_FULL;
               done  <= 1'b1;
            end
            ST_FULL: state <= ST_FULL;
            default: state <= ST_LOAD;
         endcase
      end
   end

   // Write port, word counter and error flags; independent of the FSM so the
   // final write still pulses during the first ST_FULL cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         count     <= '0;
         err       <= 1'b0;
         err_pulse <= 1'b0;
      end else begin
         wr_en     <= 1'b0;
         err_pulse <= 1'b0;
         if (clear) begin
            count <= '0;
            err   <= 1'b0;
         end else if (accept) begin
            if (invalid) begin
               err_pulse <= 1'b1;
               err       <= 1'b1;
            end else begin
               wr_en   <= 1'b1;
               wr_addr <= count[ADDR_W-1:0];
               wr_data <= word;
               count   <= count + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: full-size instance plus a 4-word instance for fill/done behaviour.
module tb_instr_encoder_loader;
   import mips_isa_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        v8 = 1'b0;
   logic        v2 = 1'b0;
   logic [3:0]  op_sel = '0;
   logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
   logic [5:0]  funct = '0;
   logic [15:0] imm16 = '0;
   logic [25:0] target26 = '0;

   logic        rdy8, we8, done8, err8, ep8;
   logic [7:0]  wa8;
   logic [31:0] wd8;
   logic [8:0]  cnt8;

   logic        rdy2, we2, done2, err2, ep2;
   logic [1:0]  wa2;
   logic [31:0] wd2;
   logic [2:0]  cnt2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   instr_encoder_loader #(.ADDR_W(8), .ERR_ON_FUNCT_JR(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(v8), .in_ready(rdy8),
      .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
      .imm16(imm16), .target26(target26), .wr_en(we8), .wr_addr(wa8), .wr_data(wd8),
      .count(cnt8), .done(done8), .err(err8), .err_pulse(ep8)
   );

   instr_encoder_loader #(.ADDR_W(2), .ERR_ON_FUNCT_JR(1)) u_small (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(v2), .in_ready(rdy2),
      .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
      .imm16(imm16), .target26(target26), .wr_en(we2), .wr_addr(wa2), .wr_data(wd2),
      .count(cnt2), .done(done2), .err(err2), .err_pulse(ep2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic set_desc(input logic [3:0] o, input logic [4:0] s, input logic [4:0] t,
                           input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
                           input logic [15:0] im, input logic [25:0] tg);
      op_sel = o; rs = s; rt = t; rd = d; shamt = sh; funct = fn; imm16 = im; target26 = tg;
   endtask

   // Present one descriptor to the large instance for one edge, sample #1 after it.
   task automatic send8(input logic [3:0] o, input logic [4:0] s, input logic [4:0] t,
                        input logic [4:0] d, input logic [4:0] sh, input logic [5:0] fn,
                        input logic [15:0] im, input logic [25:0] tg);
      @(negedge clk);
      set_desc(o, s, t, d, sh, fn, im, tg);
      v8 = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      v8 = 1'b0;
      v2 = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_ready", rdy8, 1'b0);
      chk("rst_wr_en", we8, 1'b0);
      chk("rst_addr", wa8, 8'h00);
      chk("rst_data", wd8, 32'h0);
      chk("rst_count", cnt8, 9'd0);
      chk("rst_done", done8, 1'b0);
      chk("rst_err", err8, 1'b0);
      chk("rst_ep", ep8, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ready_after_rst", rdy8, 1'b1);

      // ADDI $8,$0,5
      send8(4'd6, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0);
      chk("addi_we", we8, 1'b1);
      chk("addi_addr", wa8, 8'd0);
      chk("addi_data", wd8, 32'h20080005);
      chk("addi_count", cnt8, 9'd1);
      idle();
      chk("addi_we_pulse", we8, 1'b0);
      chk("addi_count_hold", cnt8, 9'd1);

      // restart at address 0, then back-to-back R_ALU add and JR $31
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      #1;
      chk("clr1_count", cnt8, 9'd0);
      @(negedge clk);
      clear = 1'b0;
      send8(4'd0, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20, 16'h0, 26'd0);
      chk("radd_we", we8, 1'b1);
      chk("radd_addr", wa8, 8'd0);
      chk("radd_data", wd8, 32'h01095020);
      send8(4'd1, 5'd31, 5'd3, 5'd4, 5'd5, 6'h3F, 16'hFFFF, 26'd0);
      chk("jr_we", we8, 1'b1);
      chk("jr_addr", wa8, 8'd1);
      chk("jr_data", wd8, 32'h03E00008);
      chk("jr_count", cnt8, 9'd2);

      // assorted formats, streamed
      send8(4'd2, 5'd8, 5'd9, 5'd0, 5'd0, 6'd0, 16'hFFFC, 26'd0);
      chk("lw_data", wd8, 32'h8D09FFFC);
      chk("lw_addr", wa8, 8'd2);
      send8(4'd14, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0100000);
      chk("jal_data", wd8, 32'h0C100000);
      send8(4'd12, 5'd7, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0);
      chk("lui_data", wd8, 32'h3C011234);
      send8(4'd5, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hFFFF, 26'd0);
      chk("bne_data", wd8, 32'h1422FFFF);
      send8(4'd8, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h00F0, 26'd0);
      chk("ori_data", wd8, 32'h346400F0);
      send8(4'd13, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h3FFFFFF);
      chk("j_data", wd8, 32'h0BFFFFFF);
      chk("j_addr", wa8, 8'd7);
      chk("stream_count", cnt8, 9'd8);

      // invalid descriptors
      send8(4'd15, 5'd1, 5'd2, 5'd3, 5'd4, 6'd5, 16'h1, 26'd1);
      chk("inv15_we", we8, 1'b0);
      chk("inv15_ep", ep8, 1'b1);
      chk("inv15_err", err8, 1'b1);
      chk("inv15_count", cnt8, 9'd8);
      send8(4'd0, 5'd31, 5'd0, 5'd0, 5'd0, 6'h08, 16'h0, 26'd0);
      chk("invjr_we", we8, 1'b0);
      chk("invjr_ep", ep8, 1'b1);
      chk("invjr_count", cnt8, 9'd8);
      idle();
      chk("inv_ep_drop", ep8, 1'b0);
      chk("inv_err_sticky", err8, 1'b1);

      // clear wins over a concurrent valid descriptor
      @(negedge clk);
      set_desc(4'd6, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 26'd0);
      v8 = 1'b1;
      clear = 1'b1;
      #1;
      chk("clr_ready", rdy8, 1'b0);
      @(posedge clk);
      #1;
      chk("clr_we", we8, 1'b0);
      chk("clr_count", cnt8, 9'd0);
      chk("clr_err", err8, 1'b0);
      @(negedge clk);
      clear = 1'b0;
      @(posedge clk);
      #1;
      chk("post_clr_we", we8, 1'b1);
      chk("post_clr_addr", wa8, 8'd0);
      chk("post_clr_count", cnt8, 9'd1);
      idle();

      // fill the 4-word instance
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         set_desc(4'd6, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'(i), 26'd0);
         v2 = 1'b1;
         @(posedge clk);
         #1;
         chk("fill_we", we2, 1'b1);
         chk("fill_addr", wa2, 32'(i));
         chk("fill_data", wd2, 32'h20080000 | 32'(i));
         chk("fill_count", cnt2, 32'(i + 1));
      end
      chk("full_done", done2, 1'b1);
      chk("full_ready", rdy2, 1'b0);
      @(negedge clk);
      set_desc(4'd6, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0099, 26'd0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         chk("held_we", we2, 1'b0);
         chk("held_count", cnt2, 3'd4);
         chk("held_addr", wa2, 2'd3);
      end
      @(negedge clk);
      clear = 1'b1;
      @(posedge clk);
      #1;
      chk("full_clr_we", we2, 1'b0);
      chk("full_clr_count", cnt2, 3'd0);
      chk("full_clr_done", done2, 1'b0);
      @(negedge clk);
      clear = 1'b0;
      imm16 = 16'h0055;
      @(posedge clk);
      #1;
      chk("refill_we", we2, 1'b1);
      chk("refill_addr", wa2, 2'd0);
      chk("refill_data", wd2, 32'h20080055);
      idle();

      // reset during an active write strobe
      send8(4'd7, 5'd2, 5'd3, 5'd0, 5'd0, 6'd0, 16'h00FF, 26'd0);
      chk("pre_rst_we", we8, 1'b1);
      v8 = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("async_rst_we", we8, 1'b0);
      chk("async_rst_count", cnt8, 9'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("after_rst_we", we8, 1'b0);
      chk("after_rst_count", cnt8, 9'd0);
      send8(4'd9, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'hAAAA, 26'd0);
      chk("after_rst_addr", wa8, 8'd0);
      chk("xori_data", wd8, 32'h3821AAAA);
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
